uoe_tx_arbiter: RTL and testbench
=================================

UOE_TX_ARBITER -- requirements
Module: uoe_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning number of CHDR requester streams (2..8).
REQ-002 SHALL have parameter TUSER_W, default 112, meaning per-port route word {udp_src, udp_dst, ip_dst, mac_dst}.
REQ-003 SHALL have port clk  input  1  meaning sole clock.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_port_en  input  NUM_PORTS  meaning per-port arbitration enable mask.
REQ-006 SHALL have port s_tdata  input  NUM_PORTS*64  meaning port i CHDR data in bits [64*i +: 64].
REQ-007 SHALL have port s_tuser  input  NUM_PORTS*TUSER_W  meaning port i route word in bits [TUSER_W*i +: TUSER_W].
REQ-008 SHALL have ports s_tlast, s_tvalid  input  NUM_PORTS each  meaning per-port AXI-Stream last and valid.
REQ-009 SHALL have port s_tready  output  NUM_PORTS  meaning per-port ready.
REQ-010 SHALL have ports m_tdata (64), m_tuser (TUSER_W), m_tlast (1), m_tvalid (1)  output  meaning merged stream to the UDP packet generator.
REQ-011 SHALL have port m_tready  input  1  meaning downstream ready.
REQ-012 SHALL have ports cur_grant  output  3  and busy  output  1  meaning granted port index and packet-in-progress flag.
REQ-013 SHALL have port pkt_count  output  32  meaning count of packets forwarded.

Function
REQ-014 SHALL implement states ST_IDLE and ST_PASS, packet-granular arbitration.
REQ-015 In ST_IDLE, req = s_tvalid & cfg_port_en; if req nonzero, SHALL select first set bit at or after (last_grant+1) mod NUM_PORTS, register it in cur_grant, latch that port's s_tuser into m_tuser, enter ST_PASS next cycle.
REQ-016 In ST_IDLE, SHALL drive m_tvalid=0 and s_tready=all zeros (one bubble cycle per packet).
REQ-017 In ST_PASS, SHALL drive m_tdata, m_tlast, m_tvalid combinationally from granted port, s_tready[g]=m_tready, all other s_tready=0.
REQ-018 m_tuser SHALL remain constant from grant until the tlast beat completes.
REQ-019 On m_tvalid & m_tready & m_tlast, SHALL return to ST_IDLE, set last_grant=g, increment pkt_count (wrap 0xFFFFFFFF->0).
REQ-020 Deasserting cfg_port_en[g] in ST_PASS SHALL NOT truncate the packet; mask applies at next arbitration only.
REQ-021 busy SHALL equal 1 exactly in ST_PASS.
REQ-022 m_tvalid SHALL not depend on m_tready; a beat stalled by m_tready=0 SHALL hold data stable (pass-through of source AXI compliance).
REQ-023 Non-granted ports' data SHALL never appear on m_tdata while m_tvalid=1.

Reset
REQ-024 Asserting rst at any time SHALL immediately force ST_IDLE, last_grant=NUM_PORTS-1, cur_grant=0, m_tuser=0, pkt_count=0, m_tvalid=0, s_tready=0, busy=0; a packet interrupted mid-flight is abandoned.
REQ-025 First grant after reset SHALL go to lowest-index requesting enabled port.

Structure
REQ-026 Shared package uoe_pkg SHALL hold CHDR_W=64, TUSER_W=112, state encoding constants.
REQ-027 Round-robin selection SHALL be a sub-module uoe_rr_pick (req, last_grant -> grant index, grant_valid), purely combinational.

Verification
REQ-028 Ports 0..3 each hold one 3-beat packet valid from reset release -> output order 0,1,2,3, pkt_count=4, one idle cycle between packets.
REQ-029 Port 1 sends 2 packets back-to-back, port 2 sends 1, both valid simultaneously after port 1 wins -> order 1,2,1.
REQ-030 cfg_port_en=4'b1011, all ports valid -> port 2 never granted; clearing en[0] mid-packet on port 0 -> packet 0 completes all beats.
REQ-031 m_tready toggled 1,0,0,1 during a 4-beat packet, s_tuser[g] changed mid-packet -> m_tdata stable while stalled, m_tuser equals value latched at grant.
REQ-032 rst asserted on beat 2 of 5 -> same cycle m_tvalid=0, busy=0, pkt_count=0; next grant goes to port 0.
REQ-033 pkt_count preset via 2^32-1 packets (force) -> one more packet wraps count to 0.

Source files
------------

// File: rtl/uoe_pkg.sv
// Shared constants for the UDP offload TX path: CHDR beat width, route word
// width and the arbiter FSM state encoding.
package uoe_pkg;
  localparam int CHDR_W  = 64;
  localparam int TUSER_W = 112;
  localparam int GRANT_W = 3;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_PASS = 1'b1;
endpackage

// File: rtl/uoe_tx_arbiter_if.sv
// Stream bundle around the TX arbiter: NUM_PORTS CHDR requesters in, one
// merged stream out. master = arbiter side, slave = environment side.
interface uoe_tx_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int TUSER_W   = 112
);
  import uoe_pkg::CHDR_W;

  logic [NUM_PORTS*CHDR_W-1:0]  s_tdata;
  logic [NUM_PORTS*TUSER_W-1:0] s_tuser;
  logic [NUM_PORTS-1:0]         s_tlast;
  logic [NUM_PORTS-1:0]         s_tvalid;
  logic [NUM_PORTS-1:0]         s_tready;

  logic [CHDR_W-1:0]            m_tdata;
  logic [TUSER_W-1:0]           m_tuser;
  logic                         m_tlast;
  logic                         m_tvalid;
  logic                         m_tready;

  modport master (
    input  s_tdata, s_tuser, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tuser, m_tlast, m_tvalid
  );

  modport slave (
    output s_tdata, s_tuser, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tuser, m_tlast, m_tvalid
  );
endinterface

// File: rtl/uoe_rr_pick.sv
// Combinational round-robin pick: first set request at or after
// (last_grant+1) mod NUM_PORTS.
module uoe_rr_pick #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [2:0]           last_grant_i,
  output logic [2:0]           grant_o,
  output logic                 grant_valid_o
);
  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  int                     base;

  // Rotate so bit j of rot is port (last_grant+1+j) mod NUM_PORTS, then take
  // the lowest set bit; scanning downward lets the lowest j win.
  always_comb begin
    base          = 0;
    dbl           = {req_i, req_i};
    rot           = NUM_PORTS'(dbl >> (int'(last_grant_i) + 1));
    grant_o       = '0;
    grant_valid_o = |rot;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        base    = int'(last_grant_i) + 1 + j;
        grant_o = 3'((base >= NUM_PORTS) ? (base - NUM_PORTS) : base);
      end
    end
  end
endmodule

// File: rtl/uoe_tx_arbiter.sv
// Packet-granular round-robin merge of CHDR streams toward the UDP packet
// generator; one idle bubble per packet while the route word is latched.
module uoe_tx_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int TUSER_W   = 112
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] cfg_port_en,
  uoe_tx_arbiter_if.master     bus,
  output logic [2:0]           cur_grant,
  output logic                 busy,
  output logic [31:0]          pkt_count
);
  import uoe_pkg::CHDR_W;
  import uoe_pkg::arb_state_t;
  import uoe_pkg::ST_IDLE;
  import uoe_pkg::ST_PASS;

  arb_state_t           state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           last_q, last_d;
  logic [TUSER_W-1:0]   tuser_q, tuser_d;
  logic [31:0]          pkt_count_q, pkt_count_d;

  logic [NUM_PORTS-1:0][CHDR_W-1:0]  sdata;
  logic [NUM_PORTS-1:0][TUSER_W-1:0] suser;
  logic [NUM_PORTS-1:0] req, rdy_vec;
  logic [CHDR_W-1:0]    sel_data;
  logic                 sel_last, sel_valid;
  logic [TUSER_W-1:0]   pick_user;
  logic [2:0]           pick;
  logic                 pick_vld, pass, fire;

  assign sdata = bus.s_tdata;
  assign suser = bus.s_tuser;
  assign req   = bus.s_tvalid & cfg_port_en;
  assign pass  = (state_q == ST_PASS);

  uoe_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i        (req),
    .last_grant_i (last_q),
    .grant_o      (pick),
    .grant_valid_o(pick_vld)
  );

  // Only the granted port is ever steered to the output or handed ready.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    pick_user = '0;
    rdy_vec   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == 3'(i)) begin
        sel_data   = sdata[i];
        sel_last   = bus.s_tlast[i];
        sel_valid  = bus.s_tvalid[i];
        rdy_vec[i] = pass & bus.m_tready;
      end
      if (pick == 3'(i)) pick_user = suser[i];
    end
  end

  assign bus.m_tvalid = pass & sel_valid;
  assign bus.m_tdata  = pass ? sel_data : '0;
  assign bus.m_tlast  = pass & sel_last;
  assign bus.m_tuser  = tuser_q;
  assign bus.s_tready = rdy_vec;
  assign fire         = bus.m_tvalid & bus.m_tready & bus.m_tlast;

  // The enable mask is only consulted in idle, so a port disabled mid-packet
  // still finishes its current packet.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    tuser_d     = tuser_q;
    pkt_count_d = pkt_count_q;
    if (state_q == ST_IDLE) begin
      if (pick_vld) begin
        grant_d = pick;
        tuser_d = pick_user;
        state_d = ST_PASS;
      end
    end else if (fire) begin
      state_d     = ST_IDLE;
      last_d      = grant_q;
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= 3'(NUM_PORTS - 1);
      tuser_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      tuser_q     <= tuser_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign cur_grant = grant_q;
  assign busy      = pass;
  assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_uoe_tx_arbiter.sv
// Bench for uoe_tx_arbiter: queue-fed sources, a packet-level reference
// model, a first-grant vector table and hand sequences for corner cases.
module tb_uoe_tx_arbiter;
  localparam int NP = 4;
  localparam int TW = 112;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int            warm;
    logic [NP-1:0] req;
    logic [NP-1:0] en;
    int            exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NP-1:0] en;
  logic [2:0]    cur_grant;
  logic          busy;
  logic [31:0]   pkt_count;

  uoe_tx_arbiter_if #(.NUM_PORTS(NP), .TUSER_W(TW)) bus();

  uoe_tx_arbiter #(.NUM_PORTS(NP), .TUSER_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_port_en(en),
    .bus        (bus.master),
    .cur_grant  (cur_grant),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_fail = 0;
  beat_t         q [NP][$];
  logic [TW-1:0] tu [NP];
  logic [NP-1:0] hold, vpend, drv_v;
  logic          rdy;
  bit            rnd;
  logic          rdy_pat[$];
  int            pid;
  int            ord[$];
  bit            busy_prev, stall_prev;
  logic [63:0]   stall_data;

  // reference model: packet-level grant state
  bit            pass_m;
  int            g_m, last_m;
  logic [31:0]   cnt_m;
  logic [TW-1:0] tuser_m;

  vec_t tbl[8];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(logic [NP-1:0] r, int last);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (last + k) % NP;
      if (((r >> p) & NP'(1)) != '0) return p;
    end
    return -1;
  endfunction

  task automatic push_pkt(int p, int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(p), 24'(pid), 32'(i)};
      b.last = (i == len - 1);
      q[p].push_back(b);
    end
    pid++;
  endtask

  task automatic drive();
    logic [NP-1:0]    v, l;
    logic [NP*64-1:0] d;
    logic [NP*TW-1:0] u;
    v = '0; l = '0; d = '0; u = '0;
    if (rnd) rdy = ($urandom % 3) != 0;
    else if (rdy_pat.size() > 0) rdy = rdy_pat.pop_front();
    else rdy = 1'b1;
    for (int i = 0; i < NP; i++) begin
      hold[i] = (rnd && !vpend[i]) ? (($urandom % 4) == 0) : 1'b0;
      if (q[i].size() > 0) begin
        v[i]            = !hold[i];
        l[i]            = q[i][0].last;
        d[64*i +: 64]   = q[i][0].data;
      end
      u[TW*i +: TW] = tu[i];
    end
    bus.s_tvalid = v;
    bus.s_tlast  = l;
    bus.s_tdata  = d;
    bus.s_tuser  = u;
    bus.m_tready = rdy;
    drv_v        = v;
  endtask

  task automatic check_outputs();
    logic          exp_tv;
    logic [NP-1:0] er;
    er     = '0;
    exp_tv = pass_m && drv_v[g_m];
    if (pass_m && rdy) er[g_m] = 1'b1;
    chk("busy", 128'(busy), 128'(pass_m));
    chk("cur_grant", 128'(cur_grant), 128'(g_m));
    chk("m_tvalid", 128'(bus.m_tvalid), 128'(exp_tv));
    chk("s_tready", 128'(bus.s_tready), 128'(er));
    chk("pkt_count", 128'(pkt_count), 128'(cnt_m));
    if (exp_tv && bus.m_tvalid) begin
      chk("m_tdata", 128'(bus.m_tdata), 128'(q[g_m][0].data));
      chk("m_tlast", 128'(bus.m_tlast), 128'(q[g_m][0].last));
      chk("m_tuser", 128'(bus.m_tuser), 128'(tuser_m));
    end
    if (stall_prev && bus.m_tvalid) chk("stall_hold", 128'(bus.m_tdata), 128'(stall_data));
    if (busy && !busy_prev) ord.push_back(int'(cur_grant));
    busy_prev  = busy;
    stall_prev = bus.m_tvalid && !bus.m_tready;
    stall_data = bus.m_tdata;
  endtask

  task automatic advance();
    beat_t         b;
    logic [NP-1:0] acc, r;
    acc = '0;
    @(posedge clk);
    if (pass_m) begin
      if (drv_v[g_m] && rdy) begin
        acc[g_m] = 1'b1;
        b = q[g_m].pop_front();
        if (b.last) begin
          pass_m = 1'b0;
          last_m = g_m;
          cnt_m  = cnt_m + 32'd1;
        end
      end
    end else begin
      r = drv_v & en;
      if (r != '0) begin
        g_m     = pick(r, last_m);
        tuser_m = tu[g_m];
        pass_m  = 1'b1;
      end
    end
    vpend = drv_v & ~acc;
    @(negedge clk);
  endtask

  task automatic cycle();
    drive();
    #1;
    check_outputs();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_m_tvalid", 128'(bus.m_tvalid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_pkt_count", 128'(pkt_count), 128'(0));
    chk("rst_s_tready", 128'(bus.s_tready), 128'(0));
    chk("rst_cur_grant", 128'(cur_grant), 128'(0));
    chk("rst_m_tuser", 128'(bus.m_tuser), 128'(0));
    for (int i = 0; i < NP; i++) q[i].delete();
    ord.delete();
    rdy_pat.delete();
    pass_m = 0; g_m = 0; last_m = NP - 1; cnt_m = '0; tuser_m = '0;
    vpend = '0; hold = '0; drv_v = '0;
    busy_prev = 0; stall_prev = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic bit done();
    if (pass_m) return 0;
    for (int i = 0; i < NP; i++)
      if (en[i] && q[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_idle(input int maxc, input string tag, output int cyc);
    cyc = 0;
    while (!done() && cyc < maxc) begin
      cycle();
      cyc++;
    end
    if (!done()) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, expected idle", tag, maxc);
    end
  endtask

  task automatic chk_ord(string nm, int exp[$]);
    chk({nm, "_len"}, 128'(ord.size()), 128'(exp.size()));
    if (ord.size() == exp.size())
      for (int k = 0; k < exp.size(); k++) chk(nm, 128'(ord[k]), 128'(exp[k]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, nexp;
    logic [TW-1:0] ua, ub;

    tbl[0] = '{-1, 4'b1111, 4'b1111, 0};
    tbl[1] = '{-1, 4'b1100, 4'b1111, 2};
    tbl[2] = '{-1, 4'b1111, 4'b1110, 1};
    tbl[3] = '{ 1, 4'b1111, 4'b1111, 2};
    tbl[4] = '{ 3, 4'b1111, 4'b1111, 0};
    tbl[5] = '{ 2, 4'b0101, 4'b1111, 0};
    tbl[6] = '{ 0, 4'b0001, 4'b1111, 0};
    tbl[7] = '{ 1, 4'b1011, 4'b1011, 3};

    en = '1; rnd = 0; rdy = 1'b1; pid = 0;
    for (int i = 0; i < NP; i++) tu[i] = TW'(112'h1000 + i);
    bus.s_tvalid = '0; bus.s_tlast = '0; bus.s_tdata = '0; bus.s_tuser = '0;
    bus.m_tready = 1'b1;
    @(negedge clk);
    do_reset();

    // four 3-beat packets: strict order, one bubble each => 16 cycles
    for (int p = 0; p < NP; p++) push_pkt(p, 3);
    run_idle(100, "r28", c);
    chk_ord("r28_order", '{0, 1, 2, 3});
    chk("r28_cycles", 128'(c), 128'(16));
    chk("r28_count", 128'(pkt_count), 128'(4));

    // port 2 becomes valid while port 1 holds the grant
    do_reset();
    push_pkt(1, 2); push_pkt(1, 2);
    c = 0;
    while (ord.size() == 0 && c < 10) begin cycle(); c++; end
    push_pkt(2, 2);
    run_idle(100, "r29", c);
    chk_ord("r29_order", '{1, 2, 1});

    // port 2 masked off
    do_reset();
    en = 4'b1011;
    for (int p = 0; p < NP; p++) begin push_pkt(p, 2); push_pkt(p, 2); end
    run_idle(200, "r30a", c);
    chk_ord("r30a_order", '{0, 1, 3, 0, 1, 3});
    chk("r30a_port2_left", 128'(q[2].size()), 128'(4));

    // disabling the granted port mid-packet must not truncate it
    do_reset();
    en = '1;
    push_pkt(0, 4); push_pkt(1, 1);
    cycle(); cycle();
    en[0] = 1'b0;
    run_idle(50, "r30b", c);
    chk("r30b_port0_drained", 128'(q[0].size()), 128'(0));
    chk_ord("r30b_order", '{0, 1});
    chk("r30b_count", 128'(pkt_count), 128'(2));

    // ready toggling plus route word changing after grant
    do_reset();
    en = '1;
    ua = TW'(112'hA5A5_0000_1111_2222_3333_4444_5555);
    ub = TW'(112'h5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA);
    tu[1] = ua;
    push_pkt(1, 4);
    cycle();
    tu[1] = ub;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_idle(20, "r31", c);
    chk("r31_tuser_latched", 128'(bus.m_tuser), 128'(ua));
    chk("r31_count", 128'(pkt_count), 128'(1));
    tu[1] = TW'(112'h1001);

    // reset mid-packet (second of five beats on port 0)
    do_reset();
    push_pkt(0, 5);
    cycle(); cycle();
    drive();
    #1;
    chk("r32_pre_valid", 128'(bus.m_tvalid), 128'(1));
    chk("r32_pre_beat", 128'(bus.m_tdata[31:0]), 128'(1));
    do_reset();
    push_pkt(1, 1); push_pkt(0, 1);
    run_idle(20, "r32", c);
    chk_ord("r32_order", '{0, 1});

    // counter wrap from all-ones
    do_reset();
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count_q;
    cnt_m = 32'hFFFF_FFFF;
    chk("r33_preset", 128'(pkt_count), 128'(32'hFFFF_FFFF));
    push_pkt(2, 2);
    run_idle(20, "r33", c);
    chk("r33_wrap", 128'(pkt_count), 128'(0));

    // first-grant table
    for (int t = 0; t < 8; t++) begin
      do_reset();
      if (tbl[t].warm >= 0) begin
        en = '1;
        push_pkt(tbl[t].warm, 1);
        run_idle(20, "tbl_warm", c);
      end
      ord.delete();
      en = tbl[t].en;
      for (int p = 0; p < NP; p++) if (tbl[t].req[p]) push_pkt(p, 1);
      c = 0;
      while (ord.size() == 0 && c < 10) begin cycle(); c++; end
      if (ord.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL tbl_grant[%0d]: no grant seen, expected %0d", t, tbl[t].exp);
      end else chk("tbl_grant", 128'(ord[0]), 128'(tbl[t].exp));
    end

    // randomized traffic against the model
    rnd = 1;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      en   = NP'($urandom_range(1, (1 << NP) - 1));
      nexp = 0;
      for (int p = 0; p < NP; p++) begin
        int n;
        tu[p] = TW'({$urandom, $urandom, $urandom, $urandom});
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          push_pkt(p, $urandom_range(1, 4));
          if (en[p]) nexp++;
        end
      end
      run_idle(2000, "rand", c);
      chk("rand_count", 128'(pkt_count), 128'(nexp));
    end
    rnd = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
